// File: rtl/sva_delay_checker.sv
// sva_delay_checker: multi-thread checker for "ante |-> ##[DLY_MIN:DLY_MAX] cons".
// Each antecedent takes a slot, which ages on every edge until the consequent
// arrives (success) or the window closes (failure).
// Optional statistics counters are built when SVA_CHK_STATS_EN is defined.
// Ports:
//   gclk, grst           clock, async active-high reset
//   i_chk_en             spawn enable (running threads continue when 0)
//   i_clear              sync clear of threads, flags and counters
//   i_ante, i_cons       antecedent / consequent
//   o_succ, o_fail       registered completion pulses
//   o_ovf, o_ovf_sticky  dropped-spawn pulse / sticky flag
//   o_busy, o_active_cnt slot occupancy (combinational)
//   o_succ_cnt, o_fail_cnt, o_drop_cnt  saturating totals
module sva_delay_checker #(
   parameter int NUM_THREADS = 4,
   parameter int DLY_MIN     = 1,
   parameter int DLY_MAX     = 3,
   parameter int CNT_W       = 16
) (
   input  logic                             gclk,
   input  logic                             grst,
   input  logic                             i_chk_en,
   input  logic                             i_clear,
   input  logic                             i_ante,
   input  logic                             i_cons,
   output logic                             o_succ,
   output logic                             o_fail,
   output logic                             o_ovf,
   output logic                             o_ovf_sticky,
   output logic                             o_busy,
   output logic [$clog2(NUM_THREADS+1)-1:0] o_active_cnt,
   output logic [CNT_W-1:0]                 o_succ_cnt,
   output logic [CNT_W-1:0]                 o_fail_cnt,
   output logic [CNT_W-1:0]                 o_drop_cnt
);

   localparam int AW = $clog2(DLY_MAX+1);
   localparam int PW = $clog2(NUM_THREADS+1);

   logic [NUM_THREADS-1:0] r_act;
   logic [AW-1:0]          r_age [NUM_THREADS];
   logic                   r_rst_sync;
   logic                   r_succ;
   logic                   r_fail;
   logic                   r_ovf;
   logic                   r_ovf_sticky;

   logic [NUM_THREADS-1:0] w_act_nxt;
   logic [AW-1:0]          w_age_nxt [NUM_THREADS];
   logic [AW-1:0]          w_inc [NUM_THREADS];
   logic [NUM_THREADS-1:0] w_succ_vec;
   logic [NUM_THREADS-1:0] w_fail_vec;
   logic                   w_req;
   logic                   w_found;
   logic                   w_drop;

   function automatic logic [PW-1:0] popcnt(input logic [NUM_THREADS-1:0] v);
      logic [PW-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_THREADS; i++)
         n = n + PW'(v[i]);
      return n;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_THREADS; i++)
         w_inc[i] = r_age[i] + AW'(1);
   end

   // r_rst_sync holds spawning off for the first edge after grst release,
   // so the first spawn lands on the second edge.
   assign w_req = i_ante & i_chk_en & ~i_clear & ~r_rst_sync;

   always_comb begin
      w_act_nxt  = r_act;
      w_age_nxt  = r_age;
      w_succ_vec = '0;
      w_fail_vec = '0;
      w_found    = 1'b0;
      w_drop     = 1'b0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         if (r_act[i]) begin
            if (i_cons && (w_inc[i] >= AW'(DLY_MIN))) begin
               w_succ_vec[i] = 1'b1;
               w_act_nxt[i]  = 1'b0;
            end else if (w_inc[i] == AW'(DLY_MAX)) begin
               w_fail_vec[i] = 1'b1;
               w_act_nxt[i]  = 1'b0;
            end else begin
               w_age_nxt[i] = w_inc[i];
            end
         end
      end
      // Only slots idle before the edge are candidates; slots freed by
      // this edge's evaluation become usable one edge later.
      for (int i = 0; i < NUM_THREADS; i++) begin
         if (w_req && !w_found && !r_act[i]) begin
            w_found      = 1'b1;
            w_act_nxt[i] = 1'b1;
            w_age_nxt[i] = '0;
         end
      end
      w_drop = w_req & ~w_found;
   end

   always_ff @(posedge gclk or posedge grst) begin
      if (grst) begin
         r_rst_sync   <= 1'b1;
         r_act        <= '0;
         r_succ       <= 1'b0;
         r_fail       <= 1'b0;
         r_ovf        <= 1'b0;
         r_ovf_sticky <= 1'b0;
         for (int i = 0; i < NUM_THREADS; i++)
            r_age[i] <= '0;
      end else begin
         r_rst_sync <= 1'b0;
         if (i_clear) begin
            r_act        <= '0;
            r_succ       <= 1'b0;
            r_fail       <= 1'b0;
            r_ovf        <= 1'b0;
            r_ovf_sticky <= 1'b0;
            for (int i = 0; i < NUM_THREADS; i++)
               r_age[i] <= '0;
         end else begin
            r_act        <= w_act_nxt;
            r_age        <= w_age_nxt;
            r_succ       <= |w_succ_vec;
            r_fail       <= |w_fail_vec;
            r_ovf        <= w_drop;
            r_ovf_sticky <= r_ovf_sticky | w_drop;
         end
      end
   end

   assign o_succ       = r_succ;
   assign o_fail       = r_fail;
   assign o_ovf        = r_ovf;
   assign o_ovf_sticky = r_ovf_sticky;
   assign o_busy       = |r_act;
   assign o_active_cnt = popcnt(r_act);

`ifdef SVA_CHK_STATS_EN
   localparam int SW = CNT_W + PW + 1;

   logic [CNT_W-1:0] r_succ_cnt;
   logic [CNT_W-1:0] r_fail_cnt;
   logic [CNT_W-1:0] r_drop_cnt;

   // Saturating add: totals stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [PW-1:0]    b);
      logic [SW-1:0] s;
      s = SW'(a) + SW'(b);
      if (s > SW'({CNT_W{1'b1}}))
         return '1;
      return s[CNT_W-1:0];
   endfunction

   always_ff @(posedge gclk or posedge grst) begin
      if (grst) begin
         r_succ_cnt <= '0;
         r_fail_cnt <= '0;
         r_drop_cnt <= '0;
      end else if (i_clear) begin
         r_succ_cnt <= '0;
         r_fail_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_succ_cnt <= sat_add(r_succ_cnt, popcnt(w_succ_vec));
         r_fail_cnt <= sat_add(r_fail_cnt, popcnt(w_fail_vec));
         r_drop_cnt <= sat_add(r_drop_cnt, PW'(w_drop));
      end
   end

   assign o_succ_cnt = r_succ_cnt;
   assign o_fail_cnt = r_fail_cnt;
   assign o_drop_cnt = r_drop_cnt;
`else
   assign o_succ_cnt = '0;
   assign o_fail_cnt = '0;
   assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_sva_delay_checker.sv
// tb_sva_delay_checker: directed bench for sva_delay_checker.
// Three instances share stimulus: defaults, NUM_THREADS=2, CNT_W=2.
module tb_sva_delay_checker;

`ifdef SVA_CHK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic gclk = 1'b0;
   logic grst = 1'b1;
   logic chk_en = 1'b1;
   logic clear = 1'b0;
   logic ante = 1'b0;
   logic cons = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 gclk = ~gclk;

   logic        d_succ, d_fail, d_ovf, d_stk, d_busy;
   logic [2:0]  d_act;
   logic [15:0] d_sc, d_fc, d_dc;
   logic        n_succ, n_fail, n_ovf, n_stk, n_busy;
   logic [1:0]  n_act;
   logic [15:0] n_sc, n_fc, n_dc;
   logic        s_succ, s_fail, s_ovf, s_stk, s_busy;
   logic [2:0]  s_act;
   logic [1:0]  s_sc, s_fc, s_dc;

   sva_delay_checker u_dut (
      .gclk(gclk), .grst(grst), .i_chk_en(chk_en), .i_clear(clear),
      .i_ante(ante), .i_cons(cons),
      .o_succ(d_succ), .o_fail(d_fail), .o_ovf(d_ovf),
      .o_ovf_sticky(d_stk), .o_busy(d_busy), .o_active_cnt(d_act),
      .o_succ_cnt(d_sc), .o_fail_cnt(d_fc), .o_drop_cnt(d_dc)
   );

   sva_delay_checker #(.NUM_THREADS(2)) u_nt2 (
      .gclk(gclk), .grst(grst), .i_chk_en(chk_en), .i_clear(clear),
      .i_ante(ante), .i_cons(cons),
      .o_succ(n_succ), .o_fail(n_fail), .o_ovf(n_ovf),
      .o_ovf_sticky(n_stk), .o_busy(n_busy), .o_active_cnt(n_act),
      .o_succ_cnt(n_sc), .o_fail_cnt(n_fc), .o_drop_cnt(n_dc)
   );

   sva_delay_checker #(.CNT_W(2)) u_sat (
      .gclk(gclk), .grst(grst), .i_chk_en(chk_en), .i_clear(clear),
      .i_ante(ante), .i_cons(cons),
      .o_succ(s_succ), .o_fail(s_fail), .o_ovf(s_ovf),
      .o_ovf_sticky(s_stk), .o_busy(s_busy), .o_active_cnt(s_act),
      .o_succ_cnt(s_sc), .o_fail_cnt(s_fc), .o_drop_cnt(s_dc)
   );

   function automatic int ex(input int v);
      return STATS ? v : 0;
   endfunction

   task automatic step(input logic a, input logic c);
      ante = a;
      cons = c;
      @(posedge gclk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step(1'b0, 1'b0);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge gclk);
      #1;
      total++;
      if ({d_succ, d_fail, d_ovf, d_stk, d_busy} !== 5'b0) begin
         bad++;
         $display("FAIL rst_flags got=%b exp=00000",
                  {d_succ, d_fail, d_ovf, d_stk, d_busy});
      end
      total++;
      if (d_act !== 3'd0) begin
         bad++;
         $display("FAIL rst_act got=%0d exp=0", d_act);
      end
      total++;
      if ({d_sc, d_fc, d_dc} !== 48'd0) begin
         bad++;
         $display("FAIL rst_cnt got=%0d/%0d/%0d exp=0", d_sc, d_fc, d_dc);
      end
   endtask

   task automatic test_sync_release();
      grst = 1'b0;
      step(1'b1, 1'b0);
      total++;
      if (d_act !== 3'd0) begin
         bad++;
         $display("FAIL sync_edge1_act got=%0d exp=0", d_act);
      end
      step(1'b1, 1'b0);
      total++;
      if (d_act !== 3'd1) begin
         bad++;
         $display("FAIL sync_edge2_act got=%0d exp=1", d_act);
      end
      repeat (3) step(1'b0, 1'b0);
      total++;
      if (d_fail !== 1'b1 || d_busy !== 1'b0) begin
         bad++;
         $display("FAIL sync_drain got=%b%b exp=10", d_fail, d_busy);
      end
   endtask

   task automatic test_single_success();
      do_clear();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      total++;
      if (d_succ !== 1'b0 || d_act !== 3'd1) begin
         bad++;
         $display("FAIL ss_wait got=%b/%0d exp=0/1", d_succ, d_act);
      end
      step(1'b0, 1'b1);
      total++;
      if (d_succ !== 1'b1 || d_fail !== 1'b0 || d_busy !== 1'b0) begin
         bad++;
         $display("FAIL ss_hit got=%b%b%b exp=100", d_succ, d_fail, d_busy);
      end
      total++;
      if (d_sc !== 16'(ex(1))) begin
         bad++;
         $display("FAIL ss_cnt got=%0d exp=%0d", d_sc, ex(1));
      end
      step(1'b0, 1'b0);
      total++;
      if (d_succ !== 1'b0 || d_fail !== 1'b0) begin
         bad++;
         $display("FAIL ss_after got=%b%b exp=00", d_succ, d_fail);
      end
   endtask

   task automatic test_timeout();
      do_clear();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      total++;
      if (d_fail !== 1'b0 || d_busy !== 1'b1) begin
         bad++;
         $display("FAIL to_wait got=%b%b exp=01", d_fail, d_busy);
      end
      step(1'b0, 1'b0);
      total++;
      if (d_fail !== 1'b1 || d_busy !== 1'b0 || d_succ !== 1'b0) begin
         bad++;
         $display("FAIL to_hit got=%b%b%b exp=100", d_fail, d_busy, d_succ);
      end
      total++;
      if (d_fc !== 16'(ex(1))) begin
         bad++;
         $display("FAIL to_cnt got=%0d exp=%0d", d_fc, ex(1));
      end
      step(1'b0, 1'b0);
      total++;
      if (d_fail !== 1'b0) begin
         bad++;
         $display("FAIL to_after got=%b exp=0", d_fail);
      end
   endtask

   task automatic test_same_edge_cons();
      do_clear();
      step(1'b1, 1'b1);
      total++;
      if (d_succ !== 1'b0 || d_act !== 3'd1) begin
         bad++;
         $display("FAIL se_spawn got=%b/%0d exp=0/1", d_succ, d_act);
      end
      step(1'b0, 1'b1);
      total++;
      if (d_succ !== 1'b1 || d_sc !== 16'(ex(1)) || d_busy !== 1'b0) begin
         bad++;
         $display("FAIL se_next got=%b/%0d/%b exp=1/%0d/0",
                  d_succ, d_sc, d_busy, ex(1));
      end
   endtask

   task automatic test_back_to_back();
      do_clear();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      total++;
      if (d_succ !== 1'b1 || d_act !== 3'd0) begin
         bad++;
         $display("FAIL b2b_hit got=%b/%0d exp=1/0", d_succ, d_act);
      end
      total++;
      if (d_sc !== 16'(ex(2))) begin
         bad++;
         $display("FAIL b2b_cnt got=%0d exp=%0d", d_sc, ex(2));
      end
      step(1'b0, 1'b0);
      total++;
      if (d_succ !== 1'b0 || d_sc !== 16'(ex(2))) begin
         bad++;
         $display("FAIL b2b_after got=%b/%0d exp=0/%0d", d_succ, d_sc, ex(2));
      end
   endtask

   task automatic test_continuous();
      logic [2:0] peak;
      logic       ovf_any;
      logic [9:0] nvec;
      logic [9:0] nexp;
      peak = '0;
      ovf_any = 1'b0;
      nvec = '0;
      nexp = 10'b0011001100;
      do_clear();
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b0);
         if (d_act > peak) peak = d_act;
         ovf_any = ovf_any | d_ovf;
         nvec[k] = n_ovf;
      end
      repeat (4) step(1'b0, 1'b0);
      total++;
      if (peak !== 3'd3) begin
         bad++;
         $display("FAIL cont_peak got=%0d exp=3", peak);
      end
      total++;
      if (ovf_any !== 1'b0 || d_stk !== 1'b0) begin
         bad++;
         $display("FAIL cont_ovf got=%b%b exp=00", ovf_any, d_stk);
      end
      total++;
      if (d_fc !== 16'(ex(10)) || d_busy !== 1'b0) begin
         bad++;
         $display("FAIL cont_fcnt got=%0d/%b exp=%0d/0", d_fc, d_busy, ex(10));
      end
      total++;
      if (n_stk !== 1'b1) begin
         bad++;
         $display("FAIL nt2_sticky got=%b exp=1", n_stk);
      end
      total++;
      if (nvec !== nexp) begin
         bad++;
         $display("FAIL nt2_ovf_seq got=%b exp=%b", nvec, nexp);
      end
      total++;
      if (n_fc !== 16'(ex(6)) || n_dc !== 16'(ex(4))) begin
         bad++;
         $display("FAIL nt2_cnt got=%0d/%0d exp=%0d/%0d",
                  n_fc, n_dc, ex(6), ex(4));
      end
      total++;
      if (s_fc !== 2'(ex(3))) begin
         bad++;
         $display("FAIL sat_fcnt got=%0d exp=%0d", s_fc, ex(3));
      end
   endtask

   task automatic test_clear();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      clear = 1'b1;
      step(1'b1, 1'b1);
      clear = 1'b0;
      total++;
      if (d_act !== 3'd0 || d_succ !== 1'b0 || d_busy !== 1'b0) begin
         bad++;
         $display("FAIL clr_state got=%0d/%b/%b exp=0/0/0",
                  d_act, d_succ, d_busy);
      end
      total++;
      if (d_fc !== 16'd0 || n_dc !== 16'd0) begin
         bad++;
         $display("FAIL clr_cnt got=%0d/%0d exp=0/0", d_fc, n_dc);
      end
      total++;
      if (n_stk !== 1'b0 || n_ovf !== 1'b0) begin
         bad++;
         $display("FAIL clr_ovf got=%b%b exp=00", n_stk, n_ovf);
      end
      step(1'b0, 1'b1);
      total++;
      if (d_succ !== 1'b0 || d_act !== 3'd0) begin
         bad++;
         $display("FAIL clr_after got=%b/%0d exp=0/0", d_succ, d_act);
      end
   endtask

   task automatic test_chk_en();
      do_clear();
      chk_en = 1'b0;
      step(1'b1, 1'b0);
      total++;
      if (d_act !== 3'd0) begin
         bad++;
         $display("FAIL en_off got=%0d exp=0", d_act);
      end
      chk_en = 1'b1;
      step(1'b1, 1'b0);
      chk_en = 1'b0;
      step(1'b1, 1'b0);
      total++;
      if (d_act !== 3'd1) begin
         bad++;
         $display("FAIL en_hold got=%0d exp=1", d_act);
      end
      step(1'b0, 1'b1);
      total++;
      if (d_succ !== 1'b1 || d_act !== 3'd0) begin
         bad++;
         $display("FAIL en_cont got=%b/%0d exp=1/0", d_succ, d_act);
      end
      chk_en = 1'b1;
   endtask

   task automatic test_reset_midflight();
      logic any;
      any = 1'b0;
      do_clear();
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      total++;
      if (d_act !== 3'd3 || d_sc !== 16'(ex(1)) || n_stk !== 1'b1) begin
         bad++;
         $display("FAIL mid_pre got=%0d/%0d/%b exp=3/%0d/1",
                  d_act, d_sc, n_stk, ex(1));
      end
      ante = 1'b0;
      #3;
      grst = 1'b1;
      #1;
      total++;
      if (d_busy !== 1'b0 || d_act !== 3'd0) begin
         bad++;
         $display("FAIL mid_rst_act got=%b/%0d exp=0/0", d_busy, d_act);
      end
      total++;
      if (d_sc !== 16'd0 || n_dc !== 16'd0 || n_stk !== 1'b0) begin
         bad++;
         $display("FAIL mid_rst_cnt got=%0d/%0d/%b exp=0/0/0",
                  d_sc, n_dc, n_stk);
      end
      #1;
      grst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1);
         any = any | d_succ | d_fail | n_succ | n_fail;
      end
      total++;
      if (any !== 1'b0 || d_act !== 3'd0) begin
         bad++;
         $display("FAIL mid_after got=%b/%0d exp=0/0", any, d_act);
      end
   endtask

   initial begin
      test_reset();
      test_sync_release();
      test_single_success();
      test_timeout();
      test_same_edge_cons();
      test_back_to_back();
      test_continuous();
      test_clear();
      test_chk_en();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sva_delay_checker.md
SVA_DELAY_CHECKER -- requirements
Module: sva_delay_checker

Interface
REQ-001 Parameter NUM_THREADS, default 4, is the number of concurrent evaluation slots; range 1..32.
REQ-002 Parameter DLY_MIN, default 1, is the minimum consequent delay in gclk edges; DLY_MIN >= 1.
REQ-003 Parameter DLY_MAX, default 3, is the maximum consequent delay in gclk edges; DLY_MAX >= DLY_MIN.
REQ-004 Parameter CNT_W, default 16, is the width of the statistics counters.
REQ-005 gclk  input  1  user clock; all state updates on its rising edge.
REQ-006 grst  input  1  reset, asynchronous, active-high.
REQ-007 chk_en  input  1  when 0, no new threads spawn; existing threads continue.
REQ-008 clear  input  1  synchronous clear of all threads, sticky flags and counters.
REQ-009 ante  input  1  antecedent; 1 at a sampled edge spawns a thread.
REQ-010 cons  input  1  consequent.
REQ-011 succ  output  1  registered pulse: at least one thread succeeded at the previous edge.
REQ-012 fail  output  1  registered pulse: at least one thread failed at the previous edge.
REQ-013 ovf  output  1  registered pulse: a spawn was dropped because no slot was free.
REQ-014 ovf_sticky  output  1  set by any drop; cleared only by clear or grst.
REQ-015 busy  output  1  1 when any slot is active.
REQ-016 active_cnt  output  $clog2(NUM_THREADS+1)  number of active slots.
REQ-017 succ_cnt, fail_cnt, drop_cnt  output  CNT_W each  cumulative totals.

Function
REQ-018 Each slot holds an active bit and an age field of $clog2(DLY_MAX+1) bits.
REQ-019 Spawn: at an edge with ante=1, chk_en=1 and clear=0, the lowest-index slot inactive before that edge is loaded with active=1 and age=0.
REQ-020 Evaluation: at each edge, every slot active before the edge computes A = age+1.
- cons=1 and A >= DLY_MIN: success; the slot frees.
- Otherwise, A == DLY_MAX: failure; the slot frees.
- Otherwise: age becomes A.
REQ-021 A cons sampled at the spawn edge never satisfies the thread spawned at that edge.
REQ-022 A slot freed at edge n is not allocatable until edge n+1.
REQ-023 Spawn with no allocatable slot: the thread is dropped, ovf pulses, ovf_sticky sets and drop_cnt increments.
REQ-024 Multiple completions at one edge: succ_cnt and fail_cnt each add the popcount of the completing slots; succ and fail stay single pulses.
REQ-025 Counters saturate at all-ones and never wrap.
REQ-026 A thread lives at most DLY_MAX edges; NUM_THREADS >= DLY_MAX+1 guarantees zero drops under continuous ante.
REQ-027 clear=1 at an edge frees all slots, zeroes all counters and flags, suppresses spawn at that edge, and drives succ, fail and ovf to 0 for the next cycle.
REQ-028 busy and active_cnt are combinational from slot state only.
REQ-029 Evaluation and spawn in the same edge are independent; a new spawn never sees the evaluation of that edge.

Reset
REQ-030 grst=1 asynchronously frees all slots and forces every output to 0, including all counters and ovf_sticky.
REQ-031 Release of grst is synchronised internally; the first spawn is possible at the second gclk edge after deassertion.
REQ-032 Reset asserted mid-operation discards in-flight threads with no succ or fail report.

Configuration
REQ-033 Macro SVA_CHK_STATS_EN:
- Defined: succ_cnt, fail_cnt and drop_cnt behave as specified.
- Undefined: the counter registers are not built, the three outputs are tied to 0, and succ, fail, ovf and ovf_sticky are unchanged.

Verification (defaults; SVA_CHK_STATS_EN defined)
REQ-034 ante=1 at edge 5 only, cons=1 at edge 7 only -> succ=1 for the cycle after edge 7 only; succ_cnt=1; fail never 1.
REQ-035 ante=1 at edge 5, cons=0 throughout -> fail=1 for the cycle after edge 8 only; fail_cnt=1; busy=0 after edge 8.
REQ-036 ante=1 and cons=1 at edge 5, cons=1 at edge 6 -> no success at edge 5; success at edge 6; succ_cnt=1.
REQ-037 ante=1 at edges 10-19, cons=0 -> fail_cnt=10, ovf never 1, active_cnt peaks at 3; repeat with NUM_THREADS=2 -> ovf_sticky=1 and fail_cnt+drop_cnt=10.
REQ-038 Three threads active and grst pulsed between edges -> busy=0, active_cnt=0 and all counters 0 immediately; no succ or fail afterwards without a new ante.
REQ-039 ante=1 at edges 3 and 4, cons=1 at edge 5 -> both threads succeed, succ pulses once, succ_cnt=2.
